mult_div_unit: RTL and testbench

- Iterative multiply/divide unit for the multicycle MIPS datapath. Sits directly downstream of the register file.
- Consumes the two register read operands and produces the HI/LO pair for MULT/MULTU/DIV/DIVU.
- MFHI/MFLO read `hi`/`lo`; MTHI/MTLO write them through dedicated write ports.
- The controller stalls on `busy`.

---
 rtl/mult_div_unit.sv | 162 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// The unit spends one setup edge in IDLE, XLEN iterations in CALC, and one sign-fix edge in FIX.
module mult_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [1:0]          op_q, op_d;
  logic                neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic [XLEN-1:0]     a_mag_q, a_mag_d, b_mag_q, b_mag_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                done_q, done_d;

  logic                a_neg_in_s, b_neg_in_s;
  logic [XLEN-1:0]     a_mag_in_s, b_mag_in_s;
  logic [XLEN:0]       mul_sum_s, rem_sh_s, diff_s;
  logic [2*XLEN-1:0]   mul_next_s, div_next_s, prod_s;
  logic [XLEN-1:0]     quo_s, rem_s, raw_a_s;
  logic                sign_diff_s;

  // Sign flags are only meaningful for signed ops; unsigned ops keep the raw operand.
  assign a_neg_in_s = ~op[0] & a[XLEN-1];
  assign b_neg_in_s = ~op[0] & b[XLEN-1];
  assign a_mag_in_s = a_neg_in_s ? -a : a;
  assign b_mag_in_s = b_neg_in_s ? -b : b;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
  assign mul_sum_s  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_mag_q} : {(XLEN+1){1'b0}});
  assign mul_next_s = {mul_sum_s, acc_q[XLEN-1:1]};

  // Divide: acc = {remainder, dividend/quotient}, shifted left with a trial subtract.
  assign rem_sh_s   = acc_q[2*XLEN-1:XLEN-1];
  assign diff_s     = rem_sh_s - {1'b0, b_mag_q};
  assign div_next_s = {(diff_s[XLEN] ? rem_sh_s[XLEN-1:0] : diff_s[XLEN-1:0]),
                       acc_q[XLEN-2:0], ~diff_s[XLEN]};

  assign sign_diff_s = neg_a_q ^ neg_b_q;
  assign prod_s      = sign_diff_s ? -acc_q : acc_q;
  assign quo_s       = sign_diff_s ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem_s       = neg_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
  assign raw_a_s     = neg_a_q ? -a_mag_q : a_mag_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    a_mag_d = a_mag_q;
    b_mag_d = b_mag_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (hi_we) begin
          hi_d = wdata;
        end else begin
          hi_d = hi_q;
        end
        if (lo_we) begin
          lo_d = wdata;
        end else begin
          lo_d = lo_q;
        end
        if (start) begin
          op_d    = op;
          neg_a_d = a_neg_in_s;
          neg_b_d = b_neg_in_s;
          a_mag_d = a_mag_in_s;
          b_mag_d = b_mag_in_s;
          acc_d   = op[1] ? {{XLEN{1'b0}}, a_mag_in_s} : {{XLEN{1'b0}}, b_mag_in_s};
          cnt_d   = {CW{1'b0}};
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        acc_d = op_q[1] ? div_next_s : mul_next_s;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(XLEN - 1)) begin
          state_d = FIX;
        end else begin
          state_d = CALC;
        end
      end
      FIX: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (!op_q[1]) begin
          hi_d = prod_s[2*XLEN-1:XLEN];
          lo_d = prod_s[XLEN-1:0];
        end else if (b_mag_q == {XLEN{1'b0}}) begin
          hi_d = raw_a_s;
          lo_d = {XLEN{1'b1}};
        end else begin
          hi_d = rem_s;
          lo_d = quo_s;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= {CW{1'b0}};
      op_q    <= 2'b00;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      a_mag_q <= {XLEN{1'b0}};
      b_mag_q <= {XLEN{1'b0}};
      acc_q   <= {(2*XLEN){1'b0}};
      hi_q    <= {XLEN{1'b0}};
      lo_q    <= {XLEN{1'b0}};
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      a_mag_q <= a_mag_d;
      b_mag_q <= b_mag_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases, randomized ops against an arithmetic model.
module tb_mult_div_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = 32'h0, b = 32'h0;
  logic        hi_we = 1'b0, lo_we = 1'b0;
  logic [31:0] wdata = 32'h0;
  logic        busy, done;
  logic [31:0] hi, lo;
  int checks = 0;
  int failures = 0;

  mult_div_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic ref_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] h, output logic [31:0] l);
    logic signed [63:0] sx, sy, sp, sq, sr;
    logic [63:0] up;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    case (o)
      2'b00: begin sp = sx * sy; h = sp[63:32]; l = sp[31:0]; end
      2'b01: begin up = {32'h0, x} * {32'h0, y}; h = up[63:32]; l = up[31:0]; end
      2'b10: begin
        if (y == 32'h0) begin h = x; l = 32'hFFFF_FFFF; end
        else begin sq = sx / sy; sr = sx % sy; h = sr[31:0]; l = sq[31:0]; end
      end
      default: begin
        if (y == 32'h0) begin h = x; l = 32'hFFFF_FFFF; end
        else begin h = x % y; l = x / y; end
      end
    endcase
  endtask

  // Issues one op from a post-edge point and observes 40 cycles; operands are scrambled after acceptance.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] h, output logic [31:0] l,
                        output int busy_cyc, output int done_cyc, output int done_at);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
    busy_cyc = 0; done_cyc = 0; done_at = -1; h = 32'hDEAD_BEEF; l = 32'hDEAD_BEEF;
    for (int i = 0; i < 40; i++) begin
      if (busy) busy_cyc++;
      if (done) begin done_cyc++; done_at = i; h = hi; l = lo; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
    if (hi !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=0", hi); end
    if (lo !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=0", lo); end
    checks += 4;
  endtask

  task automatic test_directed;
    logic [1:0]  t_op[8] = '{2'd1, 2'd0, 2'd0, 2'd2, 2'd3, 2'd3, 2'd2, 2'd2};
    logic [31:0] t_a[8]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFF9,
                             32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'hFFFF_FFFB};
    logic [31:0] t_b[8]  = '{32'hFFFF_FFFF, 32'h7, 32'h8000_0000, 32'h2,
                             32'h2, 32'h0, 32'hFFFF_FFFF, 32'h0};
    logic [31:0] t_hi[8] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h4000_0000, 32'hFFFF_FFFF,
                             32'h1, 32'h64, 32'h0, 32'hFFFF_FFFB};
    logic [31:0] t_lo[8] = '{32'h1, 32'hFFFF_FFEB, 32'h0, 32'hFFFF_FFFD,
                             32'h7FFF_FFFC, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] h, l;
    int bc, dc, da;
    for (int i = 0; i < 8; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], h, l, bc, dc, da);
      checks += 5;
      if (h !== t_hi[i]) begin failures++; $display("FAIL dir%0d_hi got=%h exp=%h", i, h, t_hi[i]); end
      if (l !== t_lo[i]) begin failures++; $display("FAIL dir%0d_lo got=%h exp=%h", i, l, t_lo[i]); end
      if (bc != 33) begin failures++; $display("FAIL dir%0d_busy_cycles got=%0d exp=33", i, bc); end
      if (dc != 1) begin failures++; $display("FAIL dir%0d_done_pulses got=%0d exp=1", i, dc); end
      if (da != 33) begin failures++; $display("FAIL dir%0d_done_latency got=%0d exp=33", i, da); end
    end
  endtask

  task automatic test_random;
    logic [31:0] x, y, h, l, eh, el;
    logic [1:0] o;
    int bc, dc, da;
    for (int i = 0; i < 48; i++) begin
      o = 2'(i % 4);
      x = (i % 7 == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 5))
        0: y = 32'h0;
        1: y = 32'($urandom_range(1, 15));
        2: y = 32'hFFFF_FFFF;
        default: y = 32'($urandom);
      endcase
      ref_op(o, x, y, eh, el);
      run_op(o, x, y, h, l, bc, dc, da);
      checks += 3;
      if (h !== eh) begin failures++; $display("FAIL rnd%0d_hi op=%0d a=%h b=%h got=%h exp=%h", i, o, x, y, h, eh); end
      if (l !== el) begin failures++; $display("FAIL rnd%0d_lo op=%0d a=%h b=%h got=%h exp=%h", i, o, x, y, l, el); end
      if (da != 33) begin failures++; $display("FAIL rnd%0d_done_latency got=%0d exp=33", i, da); end
    end
  endtask

  task automatic test_busy_interlock;
    int bad_hi = 0, dc = 0, busy_after = 0;
    start = 1'b1; op = 2'b01; a = 32'd6; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i < 5; i++) begin @(posedge clk); #1; end
    start = 1'b1; op = 2'b11; a = 32'd9; b = 32'd3; hi_we = 1'b1; wdata = 32'h1234;
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0; a = $urandom; b = $urandom;
    for (int i = 0; i < 45; i++) begin
      if (hi === 32'h1234) bad_hi++;
      if (done) dc++;
      if (i > 30 && busy) busy_after++;
      @(posedge clk); #1;
    end
    checks += 5;
    if (hi !== 32'h0) begin failures++; $display("FAIL ilk_hi got=%h exp=0", hi); end
    if (lo !== 32'd42) begin failures++; $display("FAIL ilk_lo got=%h exp=2a", lo); end
    if (bad_hi != 0) begin failures++; $display("FAIL ilk_hi_write_leak got=%0d exp=0", bad_hi); end
    if (dc != 1) begin failures++; $display("FAIL ilk_done_pulses got=%0d exp=1", dc); end
    if (busy_after != 0) begin failures++; $display("FAIL ilk_second_op got=%0d exp=0", busy_after); end
    lo_we = 1'b1; wdata = 32'hABCD;
    @(posedge clk); #1;
    lo_we = 1'b0;
    checks++;
    if (lo !== 32'hABCD) begin failures++; $display("FAIL ilk_lo_write got=%h exp=abcd", lo); end
  endtask

  task automatic test_idle_writes;
    logic [31:0] h, l, w;
    int bc, dc, da;
    w = $urandom;
    hi_we = 1'b1; lo_we = 1'b1; wdata = w;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    checks += 2;
    if (hi !== w) begin failures++; $display("FAIL both_we_hi got=%h exp=%h", hi, w); end
    if (lo !== w) begin failures++; $display("FAIL both_we_lo got=%h exp=%h", lo, w); end
    hi_we = 1'b1; wdata = 32'h5555_AAAA;
    start = 1'b1; op = 2'b01; a = 32'd1000; b = 32'd1000;
    @(posedge clk); #1;
    hi_we = 1'b0; start = 1'b0;
    checks++;
    if (hi !== 32'h5555_AAAA) begin failures++; $display("FAIL start_we_hi got=%h exp=5555aaaa", hi); end
    for (int i = 0; i < 34; i++) begin @(posedge clk); #1; end
    checks += 2;
    if (hi !== 32'h0) begin failures++; $display("FAIL start_we_final_hi got=%h exp=0", hi); end
    if (lo !== 32'd1000000) begin failures++; $display("FAIL start_we_final_lo got=%h exp=f4240", lo); end
  endtask

  task automatic test_reset_mid_op;
    logic [31:0] h, l;
    int bc, dc, da;
    hi_we = 1'b1; wdata = 32'h11; @(posedge clk); #1; hi_we = 1'b0;
    lo_we = 1'b1; wdata = 32'h22; @(posedge clk); #1; lo_we = 1'b0;
    start = 1'b1; op = 2'b10; a = 32'd1000; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin @(posedge clk); #1; end
    #1 rst = 1'b1;
    #1;
    checks += 4;
    if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%0b exp=0", busy); end
    if (done !== 1'b0) begin failures++; $display("FAIL rmid_done got=%0b exp=0", done); end
    if (hi !== 32'h0) begin failures++; $display("FAIL rmid_hi got=%h exp=0", hi); end
    if (lo !== 32'h0) begin failures++; $display("FAIL rmid_lo got=%h exp=0", lo); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(2'b01, 32'd3, 32'd5, h, l, bc, dc, da);
    checks += 3;
    if (h !== 32'h0) begin failures++; $display("FAIL rmid_mul_hi got=%h exp=0", h); end
    if (l !== 32'd15) begin failures++; $display("FAIL rmid_mul_lo got=%h exp=f", l); end
    if (da != 33) begin failures++; $display("FAIL rmid_mul_latency got=%0d exp=33", da); end
  endtask

  initial begin
    rst = 1'b1;
    #12;
    test_reset;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    test_directed;
    test_random;
    test_busy_interlock;
    test_idle_writes;
    test_reset_mid_op;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
